// File: rtl/riscv_exu_pkg.sv
// +-----------------------------------------------------------------------------
// | riscv_pkg : shared types for the TimeWave execute stage
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_alu_cmd_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exu_state_t;

  // One step of the serial shifter; any non-shift command passes the value through.
  function automatic logic [31:0] shift1(input alu_cmd_t cmd, input logic [31:0] val);
    case (cmd)
      ALU_SLL: shift1 = {val[30:0], 1'b0};
      ALU_SRL: shift1 = {1'b0, val[31:1]};
      ALU_SRA: shift1 = {val[31], val[31:1]};
      default: shift1 = val;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_exu_if.sv
// +-----------------------------------------------------------------------------
// | riscv_exu_if : IDU->EXU issue bus plus regfile, redirect and hazard outputs
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
interface riscv_exu_if;
  import riscv_pkg::*;

  logic            valid_i;
  logic            ready_o;
  logic [29:0]     pc_i;
  logic [4:0]      rd_addr_i;
  alu_cmd_t        alu_cmd_i;
  logic [31:0]     alu_lhs_i;
  logic [31:0]     alu_rhs_i;
  branch_alu_cmd_t branch_cmd_i;
  logic [31:0]     branch_lhs_i;
  logic [31:0]     branch_rhs_i;
  logic            branch_i;
  logic            jump_i;
  logic [29:0]     target_i;
  logic            rf_w_enable_o;
  logic [4:0]      rf_w_addr_o;
  logic [31:0]     rf_w_data_o;
  logic            pc_valid_o;
  logic [29:0]     pc_o;
  logic            pending_valid_o;
  logic [4:0]      pending_addr_o;

  modport master (
    output valid_i, pc_i, rd_addr_i, alu_cmd_i, alu_lhs_i, alu_rhs_i,
           branch_cmd_i, branch_lhs_i, branch_rhs_i, branch_i, jump_i, target_i,
    input  ready_o, rf_w_enable_o, rf_w_addr_o, rf_w_data_o, pc_valid_o, pc_o,
           pending_valid_o, pending_addr_o
  );

  modport slave (
    input  valid_i, pc_i, rd_addr_i, alu_cmd_i, alu_lhs_i, alu_rhs_i,
           branch_cmd_i, branch_lhs_i, branch_rhs_i, branch_i, jump_i, target_i,
    output ready_o, rf_w_enable_o, rf_w_addr_o, rf_w_data_o, pc_valid_o, pc_o,
           pending_valid_o, pending_addr_o
  );

endinterface
`default_nettype wire

// File: rtl/riscv_exu_branch_cmp.sv
// +-----------------------------------------------------------------------------
// | riscv_branch_cmp : combinational branch condition evaluator
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
module riscv_branch_cmp
  import riscv_pkg::*;
(
  input  branch_alu_cmd_t cmd,
  input  logic [31:0]     lhs,
  input  logic [31:0]     rhs,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (cmd)
      BR_EQ:   taken = (lhs == rhs);
      BR_NE:   taken = (lhs != rhs);
      BR_LT:   taken = ($signed(lhs) <  $signed(rhs));
      BR_GE:   taken = ($signed(lhs) >= $signed(rhs));
      BR_LTU:  taken = (lhs <  rhs);
      BR_GEU:  taken = (lhs >= rhs);
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_exu.sv
// +-----------------------------------------------------------------------------
// | riscv_exu : execute stage - inline ALU, serial shifter, branch redirect
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
module riscv_exu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  riscv_exu_if.slave  bus
);

  exu_state_t  state;
  logic [31:0] sh_val;
  logic [4:0]  sh_count;
  logic [4:0]  sh_rd;
  alu_cmd_t    sh_cmd;

  logic        rf_w_enable;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic        pc_valid;
  logic [29:0] pc;

  logic        ready;
  logic        accept;
  logic        cmp_taken;
  logic        taken;
  logic        is_shift;
  logic [4:0]  shamt;
  logic        wr_en;
  logic [31:0] alu_res;
  logic [31:0] shift_next;

  riscv_branch_cmp u_cmp (
    .cmd   (bus.branch_cmd_i),
    .lhs   (bus.branch_lhs_i),
    .rhs   (bus.branch_rhs_i),
    .taken (cmp_taken)
  );

  assign ready      = (state == IDLE) && !reset_i;
  assign accept     = bus.valid_i && ready;
  assign taken      = bus.jump_i || (bus.branch_i && cmp_taken);
  assign shamt      = bus.alu_rhs_i[4:0];
  assign is_shift   = (bus.alu_cmd_i == ALU_SLL) || (bus.alu_cmd_i == ALU_SRL) ||
                      (bus.alu_cmd_i == ALU_SRA);
  assign wr_en      = (bus.rd_addr_i != 5'd0) && !bus.branch_i;
  assign shift_next = shift1(sh_cmd, sh_val);

  // Shifts only reach this path with a zero shift amount, so they return lhs.
  always_comb begin
    alu_res = bus.alu_lhs_i;
    case (bus.alu_cmd_i)
      ALU_ADD:  alu_res = bus.alu_lhs_i + bus.alu_rhs_i;
      ALU_SUB:  alu_res = bus.alu_lhs_i - bus.alu_rhs_i;
      ALU_SLT:  alu_res = {31'b0, $signed(bus.alu_lhs_i) < $signed(bus.alu_rhs_i)};
      ALU_SLTU: alu_res = {31'b0, bus.alu_lhs_i < bus.alu_rhs_i};
      ALU_XOR:  alu_res = bus.alu_lhs_i ^ bus.alu_rhs_i;
      ALU_OR:   alu_res = bus.alu_lhs_i | bus.alu_rhs_i;
      ALU_AND:  alu_res = bus.alu_lhs_i & bus.alu_rhs_i;
      default:  alu_res = bus.alu_lhs_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      sh_val      <= 32'd0;
      sh_count    <= 5'd0;
      sh_rd       <= 5'd0;
      sh_cmd      <= ALU_ADD;
      rf_w_enable <= 1'b0;
      rf_w_addr   <= 5'd0;
      rf_w_data   <= 32'd0;
      pc_valid    <= 1'b0;
      pc          <= 30'd0;
    end else begin
      rf_w_enable <= 1'b0;
      pc_valid    <= 1'b0;
      case (state)
        IDLE: begin
          // An instruction accepted while a redirect is out is on the wrong path.
          if (accept && !pc_valid) begin
            pc_valid <= taken;
            if (taken) pc <= bus.target_i;
            if (is_shift && (shamt != 5'd0)) begin
              state    <= SHIFT;
              sh_val   <= bus.alu_lhs_i;
              sh_count <= shamt;
              sh_rd    <= bus.branch_i ? 5'd0 : bus.rd_addr_i;
              sh_cmd   <= bus.alu_cmd_i;
            end else if (wr_en) begin
              rf_w_enable <= 1'b1;
              rf_w_addr   <= bus.rd_addr_i;
              rf_w_data   <= alu_res;
            end
          end
        end
        SHIFT: begin
          sh_val   <= shift_next;
          sh_count <= sh_count - 5'd1;
          if (sh_count == 5'd1) begin
            state       <= IDLE;
            rf_w_enable <= (sh_rd != 5'd0);
            rf_w_addr   <= sh_rd;
            rf_w_data   <= shift_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o         = ready;
  assign bus.rf_w_enable_o   = rf_w_enable;
  assign bus.rf_w_addr_o     = rf_w_addr;
  assign bus.rf_w_data_o     = rf_w_data;
  assign bus.pc_valid_o      = pc_valid;
  assign bus.pc_o            = pc;
  assign bus.pending_valid_o = ((state == SHIFT) && (sh_rd != 5'd0)) || rf_w_enable;
  assign bus.pending_addr_o  = (state == SHIFT) ? sh_rd : rf_w_addr;

endmodule
`default_nettype wire

// File: tb/tb_riscv_exu.sv
// +-----------------------------------------------------------------------------
// | tb_riscv_exu : directed self-checking bench for riscv_exu
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
module tb_riscv_exu;
  import riscv_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  riscv_exu_if bus ();

  riscv_exu dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_cmd_t cmd, input logic [31:0] lhs, input logic [31:0] rhs,
                       input logic [4:0] rd, input logic br, input logic jmp,
                       input branch_alu_cmd_t bcmd, input logic [31:0] blhs,
                       input logic [31:0] brhs, input logic [29:0] tgt);
    bus.valid_i      = 1'b1;
    bus.pc_i         = 30'h10;
    bus.alu_cmd_i    = cmd;
    bus.alu_lhs_i    = lhs;
    bus.alu_rhs_i    = rhs;
    bus.rd_addr_i    = rd;
    bus.branch_i     = br;
    bus.jump_i       = jmp;
    bus.branch_cmd_i = bcmd;
    bus.branch_lhs_i = blhs;
    bus.branch_rhs_i = brhs;
    bus.target_i     = tgt;
  endtask

  task automatic alu_op(input alu_cmd_t cmd, input logic [31:0] lhs, input logic [31:0] rhs,
                        input logic [4:0] rd);
    drive(cmd, lhs, rhs, rd, 1'b0, 1'b0, BR_EQ, 32'd0, 32'd1, 30'd0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!bus.ready_o && cycles < 40) begin
      cycles++;
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    alu_op(ALU_ADD, 32'd0, 32'd0, 5'd0);
    bus.valid_i = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.ready_o), 32'd0);
    chk("reset_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("reset_waddr", 32'(bus.rf_w_addr_o), 32'd0);
    chk("reset_wdata", bus.rf_w_data_o, 32'd0);
    chk("reset_pcv", 32'(bus.pc_valid_o), 32'd0);
    chk("reset_pc", 32'(bus.pc_o), 32'd0);
    chk("reset_pend", 32'(bus.pending_valid_o), 32'd0);
    chk("reset_paddr", 32'(bus.pending_addr_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.ready_o), 32'd1);

    // Add wraps modulo 2^32
    alu_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd5);
    step();
    chk("add_wen", 32'(bus.rf_w_enable_o), 32'd1);
    chk("add_waddr", 32'(bus.rf_w_addr_o), 32'd5);
    chk("add_wdata", bus.rf_w_data_o, 32'd0);
    chk("add_pend", 32'(bus.pending_valid_o), 32'd1);
    chk("add_paddr", 32'(bus.pending_addr_o), 32'd5);
    chk("add_ready", 32'(bus.ready_o), 32'd1);

    // Back-to-back signed and unsigned compares
    alu_op(ALU_SLT, 32'h8000_0000, 32'd1, 5'd6);
    step();
    chk("slt_data", bus.rf_w_data_o, 32'd1);
    chk("slt_wen", 32'(bus.rf_w_enable_o), 32'd1);
    alu_op(ALU_SLTU, 32'h8000_0000, 32'd1, 5'd6);
    step();
    chk("sltu_data", bus.rf_w_data_o, 32'd0);
    chk("sltu_wen", 32'(bus.rf_w_enable_o), 32'd1);
    alu_op(ALU_SUB, 32'd0, 32'd1, 5'd2);
    step();
    chk("sub_data", bus.rf_w_data_o, 32'hFFFF_FFFF);
    alu_op(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd2);
    step();
    chk("xor_data", bus.rf_w_data_o, 32'h5A5A_A5A5);
    alu_op(ALU_OR, 32'h0F00_0000, 32'h0000_00F0, 5'd2);
    step();
    chk("or_data", bus.rf_w_data_o, 32'h0F00_00F0);
    alu_op(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2);
    step();
    chk("and_data", bus.rf_w_data_o, 32'h00F0_00F0);
    step();
    chk("pulse_wen_drop", 32'(bus.rf_w_enable_o), 32'd0);

    // Sra by 31: ready low for 31 cycles, then sign-filled result
    alu_op(ALU_SRA, 32'h8000_0000, 32'd31, 5'd3);
    step();
    chk("sra_busy_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("sra_pend", 32'(bus.pending_valid_o), 32'd1);
    chk("sra_paddr", 32'(bus.pending_addr_o), 32'd3);
    wait_ready(n);
    chk("sra_busy_cycles", 32'(n), 32'd31);
    chk("sra_wen", 32'(bus.rf_w_enable_o), 32'd1);
    chk("sra_waddr", 32'(bus.rf_w_addr_o), 32'd3);
    chk("sra_wdata", bus.rf_w_data_o, 32'hFFFF_FFFF);

    // Sll with shamt 0 completes in one cycle
    alu_op(ALU_SLL, 32'h1234_5678, 32'h0000_0020, 5'd4);
    step();
    chk("sll0_ready", 32'(bus.ready_o), 32'd1);
    chk("sll0_wen", 32'(bus.rf_w_enable_o), 32'd1);
    chk("sll0_wdata", bus.rf_w_data_o, 32'h1234_5678);

    // Sll by 4
    alu_op(ALU_SLL, 32'h0000_000F, 32'd4, 5'd9);
    step();
    wait_ready(n);
    chk("sll4_busy_cycles", 32'(n), 32'd4);
    chk("sll4_wdata", bus.rf_w_data_o, 32'h0000_00F0);
    chk("sll4_waddr", 32'(bus.rf_w_addr_o), 32'd9);

    // Taken Blt: one-cycle redirect, no write, next accept discarded
    drive(ALU_ADD, 32'd1, 32'd2, 5'd8, 1'b1, 1'b0, BR_LT, 32'hFFFF_FFFF, 32'd0, 30'h100);
    step();
    chk("blt_pcv", 32'(bus.pc_valid_o), 32'd1);
    chk("blt_pc", 32'(bus.pc_o), 32'h100);
    chk("blt_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("blt_ready", 32'(bus.ready_o), 32'd1);
    alu_op(ALU_ADD, 32'd1, 32'd1, 5'd7);
    step();
    chk("discard_pcv", 32'(bus.pc_valid_o), 32'd0);
    chk("discard_wen", 32'(bus.rf_w_enable_o), 32'd0);
    step();
    chk("discard_wen_late", 32'(bus.rf_w_enable_o), 32'd0);

    // Untaken Bge
    drive(ALU_ADD, 32'd1, 32'd2, 5'd8, 1'b1, 1'b0, BR_GE, 32'hFFFF_FFFF, 32'd0, 30'h200);
    step();
    chk("bge_pcv", 32'(bus.pc_valid_o), 32'd0);
    chk("bge_wen", 32'(bus.rf_w_enable_o), 32'd0);

    // JAL writes link and redirects in the same cycle
    drive(ALU_ADD, 32'h40, 32'd4, 5'd1, 1'b0, 1'b1, BR_EQ, 32'd0, 32'd1, 30'h20);
    step();
    chk("jal_wen", 32'(bus.rf_w_enable_o), 32'd1);
    chk("jal_waddr", 32'(bus.rf_w_addr_o), 32'd1);
    chk("jal_wdata", bus.rf_w_data_o, 32'h44);
    chk("jal_pcv", 32'(bus.pc_valid_o), 32'd1);
    chk("jal_pc", 32'(bus.pc_o), 32'h20);
    step();
    drive(ALU_ADD, 32'h80, 32'd4, 5'd0, 1'b0, 1'b1, BR_EQ, 32'd0, 32'd1, 30'h30);
    step();
    chk("jal0_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("jal0_pcv", 32'(bus.pc_valid_o), 32'd1);
    chk("jal0_pc", 32'(bus.pc_o), 32'h30);
    chk("jal0_pend", 32'(bus.pending_valid_o), 32'd0);
    step();

    // Reset at count 3 of a 10-bit Srl aborts the shift
    alu_op(ALU_SRL, 32'hFFFF_0000, 32'd10, 5'd12);
    step();
    repeat (7) step();
    chk("srl_busy", 32'(bus.ready_o), 32'd0);
    chk("srl_paddr", 32'(bus.pending_addr_o), 32'd12);
    reset_i = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.ready_o), 32'd0);
    chk("abort_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("abort_wdata", bus.rf_w_data_o, 32'd0);
    chk("abort_pend", 32'(bus.pending_valid_o), 32'd0);
    chk("abort_paddr", 32'(bus.pending_addr_o), 32'd0);
    chk("abort_pc", 32'(bus.pc_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    chk("post_abort_ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("post_abort_wen", 32'(bus.rf_w_enable_o), 32'd0);
    chk("post_abort_ready2", 32'(bus.ready_o), 32'd1);
    alu_op(ALU_ADD, 32'd2, 32'd3, 5'd10);
    step();
    chk("post_abort_add_wen", 32'(bus.rf_w_enable_o), 32'd1);
    chk("post_abort_add_waddr", 32'(bus.rf_w_addr_o), 32'd10);
    chk("post_abort_add_wdata", bus.rf_w_data_o, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
